// File: rtl/axis_link_pkg.sv
// Shared definitions for the host AXI Stream byte link (transmit and receive).
// Holds frame header bytes, frame-type and transmit FSM enums, and the
// command receiver's opcode nibbles so both directions use one source.
package axis_link_pkg;

  // Frame header bytes (first byte of every transmitted frame)
  localparam logic [7:0] HDR_AER  = 8'h20;
  localparam logic [7:0] HDR_READ = 8'h30;

  // Command receiver opcode nibbles
  localparam logic [3:0] OPC_WRITE = 4'b0001;
  localparam logic [3:0] OPC_READ  = 4'b0010;
  localparam logic [3:0] OPC_EVENT = 4'b0100;

  typedef enum logic {
    FT_AER,
    FT_READ
  } frame_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_B1,
    ST_B2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as the AEROUT event buffer.
// Ports: clk, rst_n (async, active-low), push/din write side,
// pop/dout read side (dout shows the head entry), full, empty.
// DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_tx.sv
// Transmit side of the host AXI Stream byte link.
// Accepts ODIN AEROUT spike events (4-phase REQ/ACK) and 16-bit controller
// read-back words (RD_VALID/RD_READY), and frames them MSB byte first:
//   AER event : 0x20, addr          (tlast on addr)
//   read word : 0x30, data_hi, data_lo (tlast on data_lo)
// Ports: clk, rst_n (async, active-low); m_axis_* 8-bit stream master;
// AEROUT_ADDR/REQ/ACK event input; RD_DATA/RD_VALID/RD_READY read-back input.
module axis_tx
  import axis_link_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SYNC_REQ   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic [7:0]  AEROUT_ADDR,
  input  logic        AEROUT_REQ,
  output logic        AEROUT_ACK,
  input  logic [15:0] RD_DATA,
  input  logic        RD_VALID,
  output logic        RD_READY
);

  logic        req_meta;
  logic        req_sync;
  logic        req;
  logic        push;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        hold_full;
  logic [15:0] hold_data;
  logic        launch_aer;
  logic        launch_read;
  tx_state_e   state;
  tx_state_e   state_nxt;
  frame_type_e ftype;
  logic [15:0] shreg;

  // REQ synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
    end else begin
      req_meta <= AEROUT_REQ;
      req_sync <= req_meta;
    end
  end

  assign req  = (SYNC_REQ != 0) ? req_sync : AEROUT_REQ;
  // Holding ACK low while full stalls ODIN instead of dropping events
  assign push = !AEROUT_ACK && req && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  AEROUT_ACK <= 1'b0;
    else if (push)               AEROUT_ACK <= 1'b1;
    else if (AEROUT_ACK && !req) AEROUT_ACK <= 1'b0;
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (AEROUT_ADDR),
    .pop  (launch_aer),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Read-back holding register; a read launch only happens while full,
  // so capture and launch never collide on the same entry.
  assign RD_READY = !hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (RD_VALID && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= RD_DATA;
    end else if (launch_read) begin
      hold_full <= 1'b0;
    end
  end

  // AER payload is loaded into the upper byte so B1 always sends shreg[15:8]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ftype <= FT_AER;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      if (launch_read) begin
        ftype <= FT_READ;
        shreg <= hold_data;
      end else if (launch_aer) begin
        ftype <= FT_AER;
        shreg <= {fifo_dout, 8'h00};
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    launch_aer    = 1'b0;
    launch_read   = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          launch_read = 1'b1;
          state_nxt   = ST_HDR;
        end else if (!fifo_empty) begin
          launch_aer = 1'b1;
          state_nxt  = ST_HDR;
        end
      end
      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = (ftype == FT_READ) ? HDR_READ : HDR_AER;
        if (m_axis_tready) state_nxt = ST_B1;
      end
      ST_B1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = shreg[15:8];
        m_axis_tlast  = (ftype == FT_AER);
        if (m_axis_tready) state_nxt = (ftype == FT_AER) ? ST_IDLE : ST_B2;
      end
      ST_B2: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = shreg[7:0];
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_tx.sv
module tb_axis_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [7:0]  AEROUT_ADDR = '0;
  logic        AEROUT_REQ = 1'b0;
  logic        AEROUT_ACK;
  logic [15:0] RD_DATA = '0;
  logic        RD_VALID = 1'b0;
  logic        RD_READY;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // received beats as {tlast, tdata}
  logic [8:0] got[$];
  bit         stalled_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  axis_tx #(
    .FIFO_DEPTH(4),
    .SYNC_REQ  (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .AEROUT_ADDR  (AEROUT_ADDR),
    .AEROUT_REQ   (AEROUT_REQ),
    .AEROUT_ACK   (AEROUT_ACK),
    .RD_DATA      (RD_DATA),
    .RD_VALID     (RD_VALID),
    .RD_READY     (RD_READY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
  endtask

  // Inputs change only at posedge+1, so negedge sees what the next edge will use
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev)
        chk("stall_hold", {23'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
            {23'd0, 1'b1, prev_last, prev_data});
      if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tdata});
      stalled_prev = m_axis_tvalid && !m_axis_tready;
      prev_data    = m_axis_tdata;
      prev_last    = m_axis_tlast;
    end
  end

  task automatic aer_send(input logic [7:0] a, input int unsigned budget, output bit acked);
    @(posedge clk); #1;
    AEROUT_ADDR = a;
    AEROUT_REQ  = 1'b1;
    acked = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (AEROUT_ACK) begin
        acked = 1'b1;
        break;
      end
    end
  endtask

  task automatic aer_release();
    bit low = 1'b0;
    @(posedge clk); #1;
    AEROUT_REQ = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!AEROUT_ACK) begin
        low = 1'b1;
        break;
      end
    end
    chk("ack_fall", {31'd0, low}, 32'd1);
  endtask

  task automatic aer_event(input logic [7:0] a);
    bit ok;
    aer_send(a, 12, ok);
    chk("ack_rise", {31'd0, ok}, 32'd1);
    aer_release();
  endtask

  task automatic rd_send(input logic [15:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    RD_DATA  = d;
    RD_VALID = 1'b1;
    for (int unsigned i = 0; i < 400; i++) begin
      @(negedge clk);
      if (RD_READY) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rd_accept", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    RD_VALID = 1'b0;
  endtask

  task automatic drain(input int unsigned n, input bit rnd);
    @(posedge clk); #1;
    for (int unsigned cyc = 0; cyc < 800; cyc++) begin
      if (got.size() >= n) break;
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b0;
    chk("beat_count", got.size(), n);
  endtask

  task automatic check_beats(input string tag, input logic [8:0] exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int unsigned i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk(tag, {23'd0, got[i]}, {23'd0, exp[i]});
    end
    got.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int unsigned acks;
    logic [8:0] exp[$];

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_ack", {31'd0, AEROUT_ACK}, 32'd0);
    chk("rst_rd_ready", {31'd0, RD_READY}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // single event, sink always ready
    got.delete();
    m_axis_tready = 1'b1;
    aer_event(8'h5A);
    drain(2, 1'b0);
    exp = '{9'h020, 9'h15A};
    check_beats("single", exp);

    // back-pressure: one event sits in the shift register, so depth+1 acked
    acks = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      aer_send(8'hA1 + 8'(k), 12, ok);
      if (!ok) break;
      acks++;
      aer_release();
    end
    chk("bp_acks", acks, 32'd5);
    chk("bp_req_stalled", {31'd0, AEROUT_ACK}, 32'd0);
    fork
      drain(12, 1'b0);
      begin
        bit ok6 = 1'b0;
        for (int unsigned i = 0; i < 100; i++) begin
          @(negedge clk);
          if (AEROUT_ACK) begin
            ok6 = 1'b1;
            break;
          end
        end
        chk("bp_ack6", {31'd0, ok6}, 32'd1);
        aer_release();
      end
    join
    exp = '{9'h020, 9'h1A1, 9'h020, 9'h1A2, 9'h020, 9'h1A3,
            9'h020, 9'h1A4, 9'h020, 9'h1A5, 9'h020, 9'h1A6};
    check_beats("bp", exp);

    // read priority over a pending AER event
    aer_event(8'h33);
    aer_event(8'h11);
    rd_send(16'hBEEF);
    repeat (3) @(negedge clk);
    drain(7, 1'b0);
    exp = '{9'h020, 9'h133, 9'h030, 9'h0BE, 9'h1EF, 9'h020, 9'h111};
    check_beats("prio", exp);

    // read handshake back-pressure, random stalls
    aer_event(8'h44);
    rd_send(16'h1234);
    @(posedge clk); #1;
    RD_DATA  = 16'hABCD;
    RD_VALID = 1'b1;
    repeat (4) @(negedge clk);
    chk("rd_ready_full", {31'd0, RD_READY}, 32'd0);
    fork
      drain(8, 1'b1);
      begin
        bit okb = 1'b0;
        for (int unsigned i = 0; i < 800; i++) begin
          @(negedge clk);
          if (RD_READY) begin
            okb = 1'b1;
            break;
          end
        end
        chk("rd_second_accept", {31'd0, okb}, 32'd1);
        @(posedge clk); #1 RD_VALID = 1'b0;
      end
    join
    exp = '{9'h020, 9'h144, 9'h030, 9'h012, 9'h134, 9'h030, 9'h0AB, 9'h1CD};
    check_beats("rd_hs", exp);

    // mid-frame reset in B1
    aer_event(8'h55);
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) break;
    end
    @(posedge clk); #1 m_axis_tready = 1'b1;
    @(posedge clk); #1 m_axis_tready = 1'b0;
    @(negedge clk);
    chk("b1_data", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, 9'h155});
    rd_send(16'h9999);
    aer_send(8'h66, 12, ok);
    chk("pre_rst_ack", {31'd0, ok}, 32'd1);
    chk("pre_rst_rd_ready", {31'd0, RD_READY}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("mrst_ack", {31'd0, AEROUT_ACK}, 32'd0);
    chk("mrst_rd_ready", {31'd0, RD_READY}, 32'd1);
    AEROUT_REQ = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    got.delete();
    aer_event(8'h77);
    drain(2, 1'b0);
    repeat (6) @(negedge clk);
    exp = '{9'h020, 9'h177};
    check_beats("post_rst", exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
